// File: rtl/pcs_rx_block_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_rx_block_sync
//  Description : Receive-side block synchroniser. Assembles 66-bit blocks
//                from unaligned SerDes words, hunts for sync-header alignment
//                by 1-bit slips and hands aligned blocks to the descrambler.
//  Ports       :
//    pcs_clk          single clock, rising edge
//    pcs_rst          asynchronous active-high reset
//    rx_serdes_data   raw received bits, bit 0 earliest on the wire
//    rx_serdes_valid  word present this cycle
//    rx_pcs_data      block payload (registered)
//    rx_pcs_header    sync header, header[0] = first received bit
//    rx_pcs_valid     one-cycle pulse per block, only while locked
//    rx_block_lock    alignment locked
//    rx_slip          one-cycle pulse per 1-bit slip
//  Revision    : 1.0  initial release
// ============================================================================
module pcs_rx_block_sync #(
   parameter int SERDES_WIDTH   = 32,
   parameter int PCS_DATA_WIDTH = 64,
   parameter int LOCK_COUNT     = 64,
   parameter int WINDOW_COUNT   = 64,
   parameter int INVALID_LIMIT  = 16
) (
   input  logic                      pcs_clk,
   input  logic                      pcs_rst,
   input  logic [SERDES_WIDTH-1:0]   rx_serdes_data,
   input  logic                      rx_serdes_valid,
   output logic [PCS_DATA_WIDTH-1:0] rx_pcs_data,
   output logic [1:0]                rx_pcs_header,
   output logic                      rx_pcs_valid,
   output logic                      rx_block_lock,
   output logic                      rx_slip
);

   localparam int c_BLK_W  = PCS_DATA_WIDTH + 2;
   // Worst case occupancy: 65 bits left over plus one full word.
   localparam int c_BUF_W  = c_BLK_W + SERDES_WIDTH - 1;
   localparam int c_CNT_W  = $clog2(c_BUF_W + 1);
   localparam int c_SH_MAX = (LOCK_COUNT > WINDOW_COUNT) ? LOCK_COUNT : WINDOW_COUNT;
   localparam int c_SH_W   = $clog2(c_SH_MAX + 1);
   localparam int c_INV_W  = $clog2(INVALID_LIMIT + 1);

   typedef enum logic [0:0] {
      S_HUNT   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   logic [c_BUF_W-1:0]        r_buf;
   logic [c_CNT_W-1:0]        r_cnt;
   state_t                    r_state;
   logic [c_SH_W-1:0]         r_sh_cnt;
   logic [c_INV_W-1:0]        r_inv_cnt;
   logic                      r_slip_pending;
   logic [PCS_DATA_WIDTH-1:0] r_pcs_data;
   logic [1:0]                r_pcs_header;
   logic                      r_pcs_valid;
   logic                      r_slip;

   // -------------------------------------------------------------------------
   // Buffer datapath
   // -------------------------------------------------------------------------
   logic                      w_extract;
   logic [c_CNT_W-1:0]        w_cnt_ext;
   logic                      w_slip_now;
   logic [c_CNT_W-1:0]        w_cnt_rem;
   logic [c_BUF_W-1:0]        w_buf_ext;
   logic [c_BUF_W-1:0]        w_buf_rem;
   logic [c_BUF_W-1:0]        w_word_pos;
   logic [c_BUF_W-1:0]        w_buf_next;
   logic [c_CNT_W-1:0]        w_cnt_next;
   logic [1:0]                w_blk_hdr;
   logic [PCS_DATA_WIDTH-1:0] w_blk_data;
   logic                      w_hdr_ok;
   logic [c_SH_W-1:0]         w_sh_inc;
   logic [c_INV_W-1:0]        w_inv_inc;

   // Extraction is decided on the registered count only, so a single block
   // can leave the buffer per cycle; with 32 bits in and 66 out that is
   // always enough to keep occupancy bounded.
   assign w_extract  = (r_cnt >= c_CNT_W'(c_BLK_W));
   assign w_cnt_ext  = w_extract ? (r_cnt - c_CNT_W'(c_BLK_W)) : r_cnt;
   // A slip needs at least one stored bit left after extraction to drop.
   assign w_slip_now = r_slip_pending & (w_cnt_ext != '0);
   assign w_cnt_rem  = w_cnt_ext - {{(c_CNT_W-1){1'b0}}, w_slip_now};

   // Bits above r_cnt are kept at zero, so the new word can simply be OR-ed
   // in at the fill position after the head has been shifted out.
   assign w_buf_ext  = w_extract  ? (r_buf >> c_BLK_W) : r_buf;
   assign w_buf_rem  = w_slip_now ? (w_buf_ext >> 1)   : w_buf_ext;
   assign w_word_pos = {{(c_BUF_W-SERDES_WIDTH){1'b0}}, rx_serdes_data} << w_cnt_rem;
   assign w_buf_next = rx_serdes_valid ? (w_buf_rem | w_word_pos) : w_buf_rem;
   assign w_cnt_next = w_cnt_rem + (rx_serdes_valid ? c_CNT_W'(SERDES_WIDTH) : '0);

   assign w_blk_hdr  = r_buf[1:0];
   assign w_blk_data = r_buf[c_BLK_W-1:2];
   assign w_hdr_ok   = w_blk_hdr[0] ^ w_blk_hdr[1];
   assign w_sh_inc   = r_sh_cnt + 1'b1;
   assign w_inv_inc  = r_inv_cnt + {{(c_INV_W-1){1'b0}}, ~w_hdr_ok};

   always_ff @(posedge pcs_clk or posedge pcs_rst) begin
      if (pcs_rst) begin
         r_buf <= '0;
         r_cnt <= '0;
      end else begin
         r_buf <= w_buf_next;
         r_cnt <= w_cnt_next;
      end
   end

   // -------------------------------------------------------------------------
   // Lock FSM and output registers, evaluated once per extracted block
   // -------------------------------------------------------------------------
   always_ff @(posedge pcs_clk or posedge pcs_rst) begin
      if (pcs_rst) begin
         r_state        <= S_HUNT;
         r_sh_cnt       <= '0;
         r_inv_cnt      <= '0;
         r_slip_pending <= 1'b0;
         r_pcs_data     <= '0;
         r_pcs_header   <= '0;
         r_pcs_valid    <= 1'b0;
         r_slip         <= 1'b0;
      end else begin
         r_slip <= w_slip_now;
         if (w_slip_now) begin
            r_slip_pending <= 1'b0;
         end

         if (w_extract) begin
            r_pcs_data   <= w_blk_data;
            r_pcs_header <= w_blk_hdr;
            case (r_state)
               S_HUNT: begin
                  if (w_hdr_ok) begin
                     if (w_sh_inc == c_SH_W'(LOCK_COUNT)) begin
                        // The completing block is itself delivered as valid.
                        r_state     <= S_LOCKED;
                        r_sh_cnt    <= '0;
                        r_inv_cnt   <= '0;
                        r_pcs_valid <= 1'b1;
                     end else begin
                        r_sh_cnt    <= w_sh_inc;
                        r_pcs_valid <= 1'b0;
                     end
                  end else begin
                     r_sh_cnt    <= '0;
                     r_pcs_valid <= 1'b0;
                     // A request arriving while one is pending is absorbed,
                     // including one that coincides with the pending slip.
                     if (!r_slip_pending) begin
                        r_slip_pending <= 1'b1;
                     end
                  end
               end
               S_LOCKED: begin
                  if (w_inv_inc == c_INV_W'(INVALID_LIMIT)) begin
                     // Takes priority over the window wrap on the same block.
                     r_state     <= S_HUNT;
                     r_sh_cnt    <= '0;
                     r_inv_cnt   <= '0;
                     r_pcs_valid <= 1'b0;
                     if (!r_slip_pending) begin
                        r_slip_pending <= 1'b1;
                     end
                  end else if (w_sh_inc == c_SH_W'(WINDOW_COUNT)) begin
                     r_sh_cnt    <= '0;
                     r_inv_cnt   <= '0;
                     r_pcs_valid <= 1'b1;
                  end else begin
                     r_sh_cnt    <= w_sh_inc;
                     r_inv_cnt   <= w_inv_inc;
                     r_pcs_valid <= 1'b1;
                  end
               end
               default: begin
                  r_state     <= S_HUNT;
                  r_pcs_valid <= 1'b0;
               end
            endcase
         end else begin
            r_pcs_valid <= 1'b0;
         end
      end
   end

   assign rx_pcs_data   = r_pcs_data;
   assign rx_pcs_header = r_pcs_header;
   assign rx_pcs_valid  = r_pcs_valid;
   assign rx_block_lock = (r_state == S_LOCKED);
   assign rx_slip       = r_slip;

endmodule
`default_nettype wire

// File: tb/tb_pcs_rx_block_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pcs_rx_block_sync
//  Description : Directed self-checking bench for pcs_rx_block_sync. Each
//                table row describes a bit stream and the hand-computed lock
//                edge, slip count, drop edge and delivered block count.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pcs_rx_block_sync;

   logic        pcs_clk;
   logic        pcs_rst;
   logic [31:0] rx_serdes_data;
   logic        rx_serdes_valid;
   logic [63:0] rx_pcs_data;
   logic [1:0]  rx_pcs_header;
   logic        rx_pcs_valid;
   logic        rx_block_lock;
   logic        rx_slip;

   pcs_rx_block_sync #(
      .SERDES_WIDTH   (32),
      .PCS_DATA_WIDTH (64),
      .LOCK_COUNT     (64),
      .WINDOW_COUNT   (64),
      .INVALID_LIMIT  (16)
   ) u_dut (
      .pcs_clk         (pcs_clk),
      .pcs_rst         (pcs_rst),
      .rx_serdes_data  (rx_serdes_data),
      .rx_serdes_valid (rx_serdes_valid),
      .rx_pcs_data     (rx_pcs_data),
      .rx_pcs_header   (rx_pcs_header),
      .rx_pcs_valid    (rx_pcs_valid),
      .rx_block_lock   (rx_block_lock),
      .rx_slip         (rx_slip)
   );

   initial pcs_clk = 1'b0;
   always #5 pcs_clk = ~pcs_clk;

   typedef struct {
      int         offset;         // zero bits ahead of block 1
      logic [1:0] sync;           // header used for good blocks
      bit         zero_data;
      int         nblk;
      int         inv_a, inv_n;   // first run of 2'b11 headers
      int         inv_b, inv_m;   // second run of 2'b11 headers
      bit         gaps;           // valid pattern 1,0,1,1,0 repeating
      int         exp_lock_edge;
      int         exp_first_blk;
      int         exp_slips;
      int         exp_drop_edge;  // 0 = lock never drops
      int         exp_vcnt;
      bit         exp_final_lock;
   } vec_t;

   vec_t        tbl [5];
   int          n_checks;
   int          n_pass;

   bit          q_bits [$];
   logic [1:0]  e_hdr [0:255];
   logic [63:0] e_dat [0:255];
   int          cur_nblk;
   int          cur_offset;
   int          first_blk;
   int          edge_n, lock_edge, drop_edge, slips, vcnt, bits_fed;
   bit          prev_lock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic do_reset();
      pcs_rst         = 1'b1;
      rx_serdes_valid = 1'b0;
      rx_serdes_data  = '0;
      repeat (2) @(posedge pcs_clk);
      @(negedge pcs_clk);
      pcs_rst = 1'b0;
   endtask

   task automatic build_stream(input vec_t v);
      logic [1:0]  h;
      logic [63:0] d;
      logic [31:0] b32;
      q_bits.delete();
      for (int i = 0; i < v.offset; i++) q_bits.push_back(1'b0);
      for (int b = 1; b <= v.nblk; b++) begin
         b32 = 32'(b);
         if ((b >= v.inv_a && b < v.inv_a + v.inv_n) || (b >= v.inv_b && b < v.inv_b + v.inv_m))
            h = 2'b11;
         else
            h = v.sync;
         d = v.zero_data ? 64'h0 : {~b32 ^ 32'h1234_5678, b32 * 32'h9E37_79B9};
         e_hdr[b] = h;
         e_dat[b] = d;
         q_bits.push_back(h[0]);
         q_bits.push_back(h[1]);
         for (int i = 0; i < 64; i++) q_bits.push_back(d[i]);
      end
      cur_nblk   = v.nblk;
      cur_offset = v.offset;
      first_blk  = v.exp_first_blk;
      edge_n = 0; lock_edge = 0; drop_edge = 0; slips = 0; vcnt = 0; bits_fed = 0;
      prev_lock = rx_block_lock;
   endtask

   task automatic feed_cycles(input int ncyc, input bit gaps);
      bit          v;
      logic [31:0] w;
      int          b;
      for (int c = 0; c < ncyc; c++) begin
         if (gaps) v = ((edge_n % 5) == 0) || ((edge_n % 5) == 2) || ((edge_n % 5) == 3);
         else      v = 1'b1;
         if (v && q_bits.size() > 0) begin
            for (int i = 0; i < 32; i++) w[i] = (q_bits.size() > 0) ? q_bits.pop_front() : 1'b0;
            rx_serdes_valid = 1'b1;
            rx_serdes_data  = w;
            bits_fed       += 32;
         end else begin
            rx_serdes_valid = 1'b0;
            rx_serdes_data  = $urandom;
         end
         @(posedge pcs_clk);
         #1;
         edge_n++;
         if (rx_slip) slips++;
         if (rx_block_lock && !prev_lock && lock_edge == 0) lock_edge = edge_n;
         if (!rx_block_lock && prev_lock && drop_edge == 0) drop_edge = edge_n;
         prev_lock = rx_block_lock;
         if (rx_pcs_valid) begin
            b = first_blk + vcnt;
            check($sformatf("valid_while_locked@%0d", edge_n), 64'(rx_block_lock), 64'd1);
            if (b <= cur_nblk) begin
               check($sformatf("blk%0d_bits_available", b),
                     64'(bits_fed >= cur_offset + 66 * b), 64'd1);
               check($sformatf("blk%0d_header", b), 64'(rx_pcs_header), 64'(e_hdr[b]));
               check($sformatf("blk%0d_data", b), rx_pcs_data, e_dat[b]);
            end else begin
               check("extra_block_index", 64'(b), 64'(cur_nblk));
            end
            vcnt++;
         end
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int words;
      build_stream(v);
      words = (q_bits.size() + 31) / 32;
      feed_cycles(v.gaps ? words * 2 + 12 : words + 12, v.gaps);
      check($sformatf("v%0d_lock_edge", idx),  64'(lock_edge), 64'(v.exp_lock_edge));
      check($sformatf("v%0d_slip_count", idx), 64'(slips),     64'(v.exp_slips));
      check($sformatf("v%0d_drop_edge", idx),  64'(drop_edge), 64'(v.exp_drop_edge));
      check($sformatf("v%0d_valid_blocks", idx), 64'(vcnt),    64'(v.exp_vcnt));
      check($sformatf("v%0d_final_lock", idx), 64'(rx_block_lock), 64'(v.exp_final_lock));
   endtask

   initial begin
      n_checks        = 0;
      n_pass          = 0;
      pcs_rst         = 1'b1;
      rx_serdes_valid = 1'b0;
      rx_serdes_data  = '0;

      // Block n ends at stream bit offset+66n; it is appended on edge
      // ceil(bits/32) (per valid word) and appears on the output one edge later.
      //          off sync  zero nblk inva invn invb invm gaps lock first slips drop vcnt final
      tbl[0] = '{0, 2'b01, 1'b0,  70,   0,   0,   0,   0, 1'b0, 133, 64, 0,   0,   7, 1'b1};
      // Header 2'b10 over a zero payload: every window opening 1..3 bits
      // early reads 2'b00, so exactly three slips precede alignment.
      tbl[1] = '{3, 2'b10, 1'b1,  75,   0,   0,   0,   0, 1'b0, 140, 67, 3,   0,   9, 1'b1};
      tbl[2] = '{0, 2'b01, 1'b0,  66,   0,   0,   0,   0, 1'b1, 220, 64, 0,   0,   3, 1'b1};
      // 15 invalids in window 65..128 and 15 more in 129..192: lock held.
      tbl[3] = '{0, 2'b01, 1'b0, 200,  70,  15, 140,  15, 1'b0, 133, 64, 0,   0, 137, 1'b1};
      // 16 invalids 70..85: block 85 ends at bit 5610 -> word 176 -> drop edge 177.
      tbl[4] = '{0, 2'b01, 1'b0,  85,  70,  16,   0,   0, 1'b0, 133, 64, 1, 177,  21, 1'b0};

      do_reset();
      check("reset_data",   rx_pcs_data,          64'h0);
      check("reset_header", 64'(rx_pcs_header),   64'h0);
      check("reset_valid",  64'(rx_pcs_valid),    64'h0);
      check("reset_lock",   64'(rx_block_lock),   64'h0);
      check("reset_slip",   64'(rx_slip),         64'h0);

      for (int i = 0; i < 5; i++) begin
         do_reset();
         run_vec(i, tbl[i]);
      end

      // Asynchronous reset mid-block while locked, then a clean relock.
      do_reset();
      build_stream(tbl[0]);
      feed_cycles(140, 1'b0);
      check("rst_lock_before", 64'(rx_block_lock), 64'd1);
      #2;
      pcs_rst         = 1'b1;
      rx_serdes_valid = 1'b0;
      #1;
      check("rst_async_data",   rx_pcs_data,        64'h0);
      check("rst_async_header", 64'(rx_pcs_header), 64'h0);
      check("rst_async_valid",  64'(rx_pcs_valid),  64'h0);
      check("rst_async_lock",   64'(rx_block_lock), 64'h0);
      check("rst_async_slip",   64'(rx_slip),       64'h0);
      repeat (2) @(posedge pcs_clk);
      @(negedge pcs_clk);
      pcs_rst = 1'b0;
      run_vec(5, tbl[0]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
